shift_seq_reg: RTL and testbench
================================

SHIFT_SEQ_REG -- requirements
Module: shift_seq_reg

Interface
REQ-001 Parameter WIDTH, default 16: register width in bits, minimum 2.
REQ-002 Parameter CNT_W, default 4: width of the shift-count field.
REQ-003 Clock  in  1  sole clock; all state updates on the rising edge.
REQ-004 Resetn  in  1  synchronous, active-low reset.
REQ-005 Load  in  1  parallel load of R.
REQ-006 R  in  WIDTH  parallel load data.
REQ-007 Start  in  1  begins a multi-step shift command; sampled only in IDLE.
REQ-008 Dir  in  1  0 = left (toward MSB), 1 = right (toward LSB); latched at Start.
REQ-009 Mode  in  2  00 FILL, 01 ROTATE, 10 EDGE, 11 ZERO; latched at Start.
REQ-010 Count  in  CNT_W  number of one-bit shifts; latched at Start.
REQ-011 SerIn  in  1  fill bit in FILL mode; sampled live on every shift edge.
REQ-012 b  out  WIDTH  register contents.
REQ-013 SerOut  out  1  bit that left the register on the most recent shift.
REQ-014 Busy  out  1  high in states SHIFT and DONE.
REQ-015 Done  out  1  one-cycle completion pulse; high only in state DONE.

Function
REQ-016 FSM states are IDLE, SHIFT and DONE. Reset state is IDLE.
REQ-017 Priority per edge: Resetn > Load > Start/shift.
REQ-018 Load=1 in any state: b<=R, state<=IDLE, no Done pulse, pending shifts discarded, SerOut unchanged.
REQ-019 In IDLE, Start=1 with Load=0: Dir, Mode and Count are latched. b does not change on that edge.
REQ-020 Transition from IDLE on Start: to SHIFT if Count!=0, otherwise to DONE.
REQ-021 In SHIFT, each edge performs exactly one shift and decrements the remaining count.
REQ-022 SHIFT moves to DONE on the edge that performs the last shift. N shifts occur on the N edges following the accept edge.
REQ-023 DONE always moves to IDLE on the next edge. Done is therefore high for exactly one cycle.
REQ-024 Start is ignored while Busy=1. Start must be re-asserted to issue a new command.
REQ-025 Left shift: b[i]<=b[i-1] for i>=1, and SerOut<=b[WIDTH-1]. Right shift: b[i]<=b[i+1] for i<WIDTH-1, and SerOut<=b[0].
REQ-026 The vacated bit (b[0] on a left shift, b[WIDTH-1] on a right shift) takes: FILL = SerIn; ROTATE = the bit shifted out; EDGE = its own previous value; ZERO = 0.
REQ-027 In IDLE with no Load, b and SerOut hold.
REQ-028 The remaining-count register is CNT_W bits wide. Count = 2^CNT_W-1 performs that many shifts with no wrap.

Reset
REQ-029 While Resetn=0 at an edge: b=0, SerOut=0, Busy=0, Done=0, state=IDLE, and all latched command fields are cleared.
REQ-030 Reset asserted mid-command aborts the command with no Done pulse. The first edge with Resetn=1 behaves as IDLE.

Structure
REQ-031 A shared package shift_seq_pkg holds the Mode encodings (FILL, ROTATE, EDGE, ZERO), the Dir encodings, and the FSM state encoding.
REQ-032 One sub-module, shift_step, holds the single-step shift datapath. It is combinational and takes b, Dir, Mode and SerIn, and returns next b and the out bit.
REQ-033 FSM, counter and registers live in shift_seq_reg. No other sub-modules are used.

Verification (WIDTH=16, CNT_W=4)
REQ-034 Reset: Resetn=0 for 2 cycles after arbitrary activity -> b=16'h0000, SerOut=0, Busy=0, Done=0.
REQ-035 Load 16'h0001, then Start with Dir=0, Mode=ZERO, Count=3 -> b=0002/0004/0008 on the next 3 edges; Busy high for 4 cycles; Done high for 1 cycle after the last shift; Start ignored during Busy.
REQ-036 Load 16'h0001, then Start with Dir=1, Mode=ROTATE, Count=1 -> b=16'h8000, SerOut=1. Repeat with Mode=FILL, SerIn=0 -> b=16'h0000, SerOut=1.
REQ-037 Load 16'h0001, then Start with Dir=0, Mode=EDGE, Count=2 -> b=16'h0003, then 16'h0007; SerOut=0.
REQ-038 Start with Count=8, then Load=1 with R=16'hA5A5 on the 3rd shift edge -> b=16'hA5A5, Busy=0 next cycle, Done never asserted.
REQ-039 Start with Count=0 -> b unchanged, Done high for one cycle on the cycle after accept. Load and Start asserted on the same edge -> load wins and no command is accepted.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared encodings for the multi-step shift sequencer.
// Also holds the fill-bit selection used by the one-step datapath.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    MODE_FILL   = 2'b00,
    MODE_ROTATE = 2'b01,
    MODE_EDGE   = 2'b10,
    MODE_ZERO   = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Value that enters the vacated end of the register.
  // edge_bit is the vacated position's own previous value.
  function automatic logic fill_bit(input mode_e mode,
                                    input logic  ser_in,
                                    input logic  out_bit,
                                    input logic  edge_bit);
    logic f;
    case (mode)
      MODE_FILL:   f = ser_in;
      MODE_ROTATE: f = out_bit;
      MODE_EDGE:   f = edge_bit;
      default:     f = 1'b0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational one-bit shift of the register in the latched direction/mode.
// Produces the next register value and the bit that falls off the end.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] b_i,
  input  dir_e             dir_i,
  input  mode_e            mode_i,
  input  logic             ser_in_i,
  output logic [WIDTH-1:0] b_o,
  output logic             out_o
);

  logic fill;

  always_comb begin
    b_o   = b_i;
    out_o = 1'b0;
    fill  = 1'b0;
    if (dir_i == DIR_LEFT) begin
      out_o = b_i[WIDTH-1];
      fill  = fill_bit(mode_i, ser_in_i, b_i[WIDTH-1], b_i[0]);
      b_o   = {b_i[WIDTH-2:0], fill};
    end else begin
      out_o = b_i[0];
      fill  = fill_bit(mode_i, ser_in_i, b_i[0], b_i[WIDTH-1]);
      b_o   = {fill, b_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/shift_seq_reg.sv
// Shift register that executes Count one-bit shifts per accepted Start command.
//   state    | meaning
//   ST_IDLE  | holding b; accepts Load or Start
//   ST_SHIFT | one shift per edge until the remaining count is exhausted
//   ST_DONE  | single-cycle completion pulse, then back to idle
module shift_seq_reg
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Load,
  input  logic [WIDTH-1:0] R,
  input  logic             Start,
  input  logic             Dir,
  input  logic [1:0]       Mode,
  input  logic [CNT_W-1:0] Count,
  input  logic             SerIn,
  output logic [WIDTH-1:0] b,
  output logic             SerOut,
  output logic             Busy,
  output logic             Done
);

  state_e           state_q;
  logic [WIDTH-1:0] b_q;
  logic             ser_out_q;
  dir_e             dir_q;
  mode_e            mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] b_d;
  logic             ser_out_d;

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .b_i     (b_q),
    .dir_i   (dir_q),
    .mode_i  (mode_q),
    .ser_in_i(SerIn),
    .b_o     (b_d),
    .out_o   (ser_out_d)
  );

  // Load overrides everything but reset and silently drops any pending shifts.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q   <= ST_IDLE;
      b_q       <= '0;
      ser_out_q <= 1'b0;
      dir_q     <= DIR_LEFT;
      mode_q    <= MODE_FILL;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (Load) begin
      state_q <= ST_IDLE;
      b_q     <= R;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            dir_q  <= dir_e'(Dir);
            mode_q <= mode_e'(Mode);
            cnt_q  <= Count;
            busy_q <= 1'b1;
            if (Count == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          b_q       <= b_d;
          ser_out_q <= ser_out_d;
          cnt_q     <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign b      = b_q;
  assign SerOut = ser_out_q;
  assign Busy   = busy_q;
  assign Done   = done_q;

endmodule

// File: tb/tb_shift_seq_reg.sv
// Directed bench for shift_seq_reg (WIDTH=16, CNT_W=4) with hand-computed expectations.
module tb_shift_seq_reg;
  import shift_seq_pkg::*;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Load;
  logic [15:0] R;
  logic        Start;
  logic        Dir;
  logic [1:0]  Mode;
  logic [3:0]  Count;
  logic        SerIn;
  logic [15:0] b;
  logic        SerOut;
  logic        Busy;
  logic        Done;

  int total = 0;
  int bad   = 0;

  shift_seq_reg #(.WIDTH(16), .CNT_W(4)) dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .Load  (Load),
    .R     (R),
    .Start (Start),
    .Dir   (Dir),
    .Mode  (Mode),
    .Count (Count),
    .SerIn (SerIn),
    .b     (b),
    .SerOut(SerOut),
    .Busy  (Busy),
    .Done  (Done)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] eb, input logic eso,
                         input logic ebusy, input logic edone);
    chk({tag, ".b"}, b, eb);
    chk({tag, ".serout"}, {15'd0, SerOut}, {15'd0, eso});
    chk({tag, ".busy"}, {15'd0, Busy}, {15'd0, ebusy});
    chk({tag, ".done"}, {15'd0, Done}, {15'd0, edone});
  endtask

  task automatic load(input logic [15:0] v);
    Load = 1'b1; R = v; Start = 1'b0;
    tick();
    Load = 1'b0;
  endtask

  task automatic start(input logic d, input mode_e m, input logic [3:0] c);
    Start = 1'b1; Dir = d; Mode = m; Count = c;
    tick();
    Start = 1'b0;
  endtask

  initial begin
    Resetn = 1'b1; Load = 1'b0; R = '0; Start = 1'b0;
    Dir = 1'b0; Mode = MODE_FILL; Count = '0; SerIn = 1'b0;

    // Arbitrary activity, then reset for two cycles mid-command
    load(16'hFFFF);
    start(1'b0, MODE_ROTATE, 4'd5);
    tick();
    Resetn = 1'b0;
    tick();
    tick();
    chk_all("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    Resetn = 1'b1;
    tick();
    chk_all("post_reset_idle", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Left ZERO x3, Start held high during Busy must be ignored
    load(16'h0001);
    chk("load_0001", b, 16'h0001);
    Start = 1'b1; Dir = 1'b0; Mode = MODE_ZERO; Count = 4'd3;
    tick();
    chk_all("zero_accept", 16'h0001, 1'b0, 1'b1, 1'b0);
    Count = 4'd7;
    tick();
    chk_all("zero_s1", 16'h0002, 1'b0, 1'b1, 1'b0);
    tick();
    chk_all("zero_s2", 16'h0004, 1'b0, 1'b1, 1'b0);
    tick();
    chk_all("zero_s3", 16'h0008, 1'b0, 1'b1, 1'b1);
    tick();
    chk_all("zero_back_idle", 16'h0008, 1'b0, 1'b0, 1'b0);
    Start = 1'b0;
    tick();
    chk_all("zero_hold", 16'h0008, 1'b0, 1'b0, 1'b0);

    // Right ROTATE x1
    load(16'h0001);
    start(1'b1, MODE_ROTATE, 4'd1);
    tick();
    chk_all("rot_r1", 16'h8000, 1'b1, 1'b1, 1'b1);
    tick();

    // Right FILL x1 with SerIn=0
    load(16'h0001);
    SerIn = 1'b0;
    start(1'b1, MODE_FILL, 4'd1);
    tick();
    chk_all("fill_r1", 16'h0000, 1'b1, 1'b1, 1'b1);
    tick();

    // Left FILL x2 with SerIn=1
    load(16'h8000);
    SerIn = 1'b1;
    start(1'b0, MODE_FILL, 4'd2);
    tick();
    chk_all("fill_l1", 16'h0001, 1'b1, 1'b1, 1'b0);
    tick();
    chk_all("fill_l2", 16'h0003, 1'b0, 1'b1, 1'b1);
    SerIn = 1'b0;
    tick();

    // Left EDGE x2
    load(16'h0001);
    start(1'b0, MODE_EDGE, 4'd2);
    tick();
    chk_all("edge_l1", 16'h0003, 1'b0, 1'b1, 1'b0);
    tick();
    chk_all("edge_l2", 16'h0007, 1'b0, 1'b1, 1'b1);
    tick();

    // Right EDGE x3 replicates the MSB
    load(16'h8000);
    start(1'b1, MODE_EDGE, 4'd3);
    tick(); tick(); tick();
    chk_all("edge_r3", 16'hF000, 1'b0, 1'b1, 1'b1);
    tick();

    // Load aborts an 8-shift command on the 3rd shift edge
    load(16'hF000);
    start(1'b0, MODE_ZERO, 4'd8);
    tick();
    chk_all("abort_s1", 16'hE000, 1'b1, 1'b1, 1'b0);
    tick();
    chk_all("abort_s2", 16'hC000, 1'b1, 1'b1, 1'b0);
    Load = 1'b1; R = 16'hA5A5;
    tick();
    Load = 1'b0;
    chk_all("abort_load", 16'hA5A5, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("abort_no_done", {15'd0, Done}, 16'h0000);
    end
    chk_all("abort_hold", 16'hA5A5, 1'b1, 1'b0, 1'b0);

    // Count=0 goes straight to DONE
    start(1'b0, MODE_ZERO, 4'd0);
    chk_all("cnt0_done", 16'hA5A5, 1'b1, 1'b1, 1'b1);
    tick();
    chk_all("cnt0_idle", 16'hA5A5, 1'b1, 1'b0, 1'b0);

    // Load and Start on the same edge: load wins, no command
    Load = 1'b1; R = 16'h1234; Start = 1'b1; Dir = 1'b0; Mode = MODE_ZERO; Count = 4'd2;
    tick();
    Load = 1'b0; Start = 1'b0;
    chk_all("ld_st_same", 16'h1234, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("ld_st_none", 16'h1234, 1'b1, 1'b0, 1'b0);

    // Maximum count: 15 shifts, no wrap
    load(16'h0001);
    start(1'b0, MODE_ZERO, 4'd15);
    for (int i = 0; i < 14; i++) tick();
    chk_all("max_s14", 16'h4000, 1'b0, 1'b1, 1'b0);
    tick();
    chk_all("max_s15", 16'h8000, 1'b0, 1'b1, 1'b1);
    tick();
    chk_all("max_idle", 16'h8000, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
